llc_flush_walker: RTL and testbench

LLC_FLUSH_WALKER -- requirements
Module: llc_flush_walker

---
 rtl/llc_flush_walker.sv | 93 +++++++++
 tb/tb_llc_flush_walker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_flush_walker.sv
// llc_flush_walker: clears the LLC tag/state memory after reset, then on request walks every set,
// writes back dirty lines one way at a time and invalidates the set.
module llc_flush_walker #(
   parameter int SET_BITS = 9,
   parameter int NUM_WAYS = 16,
   parameter int WAY_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_start,
   input  logic [NUM_WAYS-1:0] rd_valid_vec,
   input  logic [NUM_WAYS-1:0] rd_dirty_vec,
   input  logic                wb_ready,
   output logic                mem_en,
   output logic [SET_BITS-1:0] mem_set,
   output logic [NUM_WAYS-1:0] mem_wr_rst_flush,
   output logic                wb_valid,
   output logic [SET_BITS-1:0] wb_set,
   output logic [WAY_BITS-1:0] wb_way,
   output logic                busy,
   output logic                init_done,
   output logic                flush_done
);
   localparam logic [2:0] INIT = 3'd0;
   localparam logic [2:0] IDLE = 3'd1;
   localparam logic [2:0] RD   = 3'd2;
   localparam logic [2:0] CAPT = 3'd3;
   localparam logic [2:0] WB   = 3'd4;
   localparam logic [2:0] CLR  = 3'd5;
   localparam logic [2:0] DONE = 3'd6;
   logic [2:0]          state;
   logic [SET_BITS-1:0] set_cnt;
   logic [NUM_WAYS-1:0] dmask, vmask, low_bit, cap_d;
   logic [WAY_BITS-1:0] low_idx;
   logic                last;
   assign cap_d   = rd_dirty_vec & rd_valid_vec;
   assign low_bit = dmask & (~dmask + NUM_WAYS'(1));
   assign last    = set_cnt == '1;
   always_comb begin
      low_idx = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--)
         if (dmask[i]) low_idx = WAY_BITS'(i);
   end
   // set_cnt wraps to 0 on its own when advancing past the last set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= INIT;
         set_cnt   <= '0;
         dmask     <= '0;
         vmask     <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               set_cnt <= set_cnt + SET_BITS'(1);
               if (last) begin
                  state     <= IDLE;
                  init_done <= 1'b1;
               end
            end
            IDLE: if (flush_start) begin
               state   <= RD;
               set_cnt <= '0;
            end
            RD: state <= CAPT;
            CAPT: begin
               vmask <= rd_valid_vec;
               dmask <= cap_d;
               state <= |cap_d ? WB : |rd_valid_vec ? CLR : last ? DONE : RD;
               if (~|rd_valid_vec) set_cnt <= set_cnt + SET_BITS'(1);
            end
            WB: if (wb_ready) begin
               dmask <= dmask & ~low_bit;
               if (dmask == low_bit) state <= CLR;
            end
            CLR: begin
               state   <= last ? DONE : RD;
               set_cnt <= set_cnt + SET_BITS'(1);
            end
            DONE: state <= IDLE;
            default: state <= INIT;
         endcase
      end
   end
   assign busy             = state != IDLE;
   assign mem_en           = state == INIT || state == RD || state == CLR;
   assign mem_set          = set_cnt;
   assign mem_wr_rst_flush = state == INIT ? '1 : state == CLR ? vmask : '0;
   assign wb_valid         = state == WB;
   assign wb_set           = set_cnt;
   assign wb_way           = low_idx;
   assign flush_done       = state == DONE;
endmodule

// File: tb/tb_llc_flush_walker.sv
// tb_llc_flush_walker: directed bench with a bench-side memory and a transaction-level expected-trace model.
module tb_llc_flush_walker;
   logic clk = 1'b0, rst = 1'b0, flush_start = 1'b0, wb_ready = 1'b0;
   logic [3:0] rd_valid_vec = '0, rd_dirty_vec = '0;
   logic       mem_en, wb_valid, busy, init_done, flush_done;
   logic [1:0] mem_set, wb_set, wb_way;
   logic [3:0] mem_wr_rst_flush;
   typedef struct packed {
      logic busy, en;
      logic [1:0] set;
      logic [3:0] clr;
      logic wbv;
      logic [1:0] ws, ww;
      logic fd, idn;
   } exp_t;
   exp_t q[$];
   exp_t dflt;
   logic [3:0] mem_v[4], mem_d[4];
   logic [3:0] rv = '0, rdd = '0;
   logic [3:0] wb_log[$];
   logic       saw_clr;
   int passed = 0, total = 0, stall_left = 0, busy_cnt = 0, fd_cnt = 0, wbv_cnt = 0;

   llc_flush_walker #(.SET_BITS(2), .NUM_WAYS(4), .WAY_BITS(2)) dut (
      .clk(clk), .rst(rst), .flush_start(flush_start), .rd_valid_vec(rd_valid_vec),
      .rd_dirty_vec(rd_dirty_vec), .wb_ready(wb_ready), .mem_en(mem_en), .mem_set(mem_set),
      .mem_wr_rst_flush(mem_wr_rst_flush), .wb_valid(wb_valid), .wb_set(wb_set), .wb_way(wb_way),
      .busy(busy), .init_done(init_done), .flush_done(flush_done));

   always #5 clk = ~clk;

   function automatic exp_t base(input logic b, input logic idn);
      exp_t e;
      e = '0;
      e.busy = b;
      e.idn = idn;
      return e;
   endfunction
   function automatic exp_t rst_e();
      exp_t e;
      e = base(1'b1, 1'b0);
      e.en = 1'b1;
      e.clr = 4'hf;
      return e;
   endfunction
   function automatic exp_t init_e(input logic [1:0] s);
      exp_t e;
      e = rst_e();
      e.set = s;
      return e;
   endfunction
   function automatic exp_t mem_e(input logic [1:0] s, input logic [3:0] c);
      exp_t e;
      e = base(1'b1, 1'b1);
      e.en = 1'b1;
      e.set = s;
      e.clr = c;
      return e;
   endfunction
   function automatic exp_t wb_e(input logic [1:0] s, input logic [1:0] w);
      exp_t e;
      e = base(1'b1, 1'b1);
      e.wbv = 1'b1;
      e.ws = s;
      e.ww = w;
      return e;
   endfunction
   function automatic exp_t done_e();
      exp_t e;
      e = base(1'b1, 1'b1);
      e.fd = 1'b1;
      return e;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Expected per-cycle trace of a whole flush, derived from the set contents at request time
   task automatic plan_flush(input int stall);
      bit first = 1'b1;
      q.push_back(base(1'b0, 1'b1));
      for (int s = 0; s < 4; s++) begin
         logic [3:0] v, d;
         v = mem_v[s];
         d = mem_d[s] & v;
         q.push_back(mem_e(2'(s), 4'h0));
         q.push_back(base(1'b1, 1'b1));
         for (int w = 0; w < 4; w++)
            if (d[w]) begin
               repeat ((first ? stall : 0) + 1) q.push_back(wb_e(2'(s), 2'(w)));
               first = 1'b0;
            end
         if (v != 0) q.push_back(mem_e(2'(s), v));
      end
      q.push_back(done_e());
      stall_left = stall;
   endtask

   task automatic tick();
      exp_t e;
      logic ok;
      @(negedge clk);
      e = q.size() > 0 ? q.pop_front() : dflt;
      ok = busy == e.busy && mem_en == e.en && (!e.en || mem_set == e.set) &&
           mem_wr_rst_flush == e.clr && wb_valid == e.wbv &&
           (!e.wbv || (wb_set == e.ws && wb_way == e.ww)) && flush_done == e.fd && init_done == e.idn;
      total++;
      if (ok === 1'b1) passed++;
      else $display("FAIL cycle @%0t: got busy=%b en=%b set=%0d clr=%b wbv=%b ws=%0d ww=%0d fd=%b idn=%b, expected busy=%b en=%b set=%0d clr=%b wbv=%b ws=%0d ww=%0d fd=%b idn=%b",
                    $time, busy, mem_en, mem_set, mem_wr_rst_flush, wb_valid, wb_set, wb_way, flush_done, init_done,
                    e.busy, e.en, e.set, e.clr, e.wbv, e.ws, e.ww, e.fd, e.idn);
      wb_ready = stall_left == 0;
      if (wb_valid && !wb_ready) stall_left--;
      if (wb_valid && wb_ready) wb_log.push_back({wb_set, wb_way});
      if (busy) busy_cnt++;
      if (flush_done) fd_cnt++;
      if (wb_valid) wbv_cnt++;
      if (mem_en && init_done && mem_set == 2'd2 && mem_wr_rst_flush == 4'b1011) saw_clr = 1'b1;
      if (mem_en) begin
         rv = mem_v[mem_set];
         rdd = mem_d[mem_set];
         mem_v[mem_set] = mem_v[mem_set] & ~mem_wr_rst_flush;
         mem_d[mem_set] = mem_d[mem_set] & ~mem_wr_rst_flush;
      end
      @(posedge clk);
      #1;
      rd_valid_vec = rv;
      rd_dirty_vec = rdd;
   endtask

   task automatic release_init(input int pulse);
      rst = 1'b1;
      q.delete();
      for (int s = 0; s < 4; s++) q.push_back(init_e(2'(s)));
      for (int i = 0; i < 4; i++) begin
         flush_start = i == pulse;
         tick();
         flush_start = 1'b0;
      end
      dflt = base(1'b0, 1'b1);
      repeat (3) tick();
      chk("init_done_held", int'(init_done), 1);
   endtask

   task automatic start_flush(input int stall, input int pulse_at);
      busy_cnt = 0;
      fd_cnt = 0;
      wbv_cnt = 0;
      wb_log.delete();
      saw_clr = 1'b0;
      flush_start = 1'b1;
      plan_flush(stall);
      tick();
      flush_start = 1'b0;
      for (int n = 1; n < 200 && q.size() > 0; n++) begin
         flush_start = n == pulse_at;
         tick();
         flush_start = 1'b0;
      end
      chk("walk_timeout", q.size(), 0);
      repeat (2) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int s = 0; s < 4; s++) begin
         mem_v[s] = 4'hf;
         mem_d[s] = 4'h5;
      end
      dflt = rst_e();
      repeat (3) tick();
      release_init(1);
      for (int s = 0; s < 4; s++) chk("init_cleared", int'(mem_v[s]), 0);
      // empty cache: 4 sets x 2 cycles plus the done cycle
      start_flush(0, 0);
      chk("empty_busy", busy_cnt, 9);
      chk("empty_done", fd_cnt, 1);
      chk("empty_wb", wbv_cnt, 0);
      // set 2 with two dirty ways, consumer always ready
      mem_v[2] = 4'b1011;
      mem_d[2] = 4'b1010;
      start_flush(0, 0);
      chk("wb_count", wb_log.size(), 2);
      if (wb_log.size() == 2) begin
         chk("wb_first", int'(wb_log[0]), 4'b1001);
         chk("wb_second", int'(wb_log[1]), 4'b1011);
      end
      chk("clr_seen", int'(saw_clr), 1);
      chk("set2_cleared", int'(mem_v[2]), 0);
      chk("dirty_busy", busy_cnt, 12);
      chk("dirty_done", fd_cnt, 1);
      // same with five stall cycles on the first writeback
      mem_v[2] = 4'b1011;
      mem_d[2] = 4'b1010;
      start_flush(5, 0);
      chk("stall_wbv_cycles", wbv_cnt, 7);
      chk("stall_wb_count", wb_log.size(), 2);
      chk("stall_done", fd_cnt, 1);
      // ignored request in the middle of a walk
      mem_v[1] = 4'b0001;
      mem_d[1] = 4'b0000;
      start_flush(0, 3);
      chk("midflush_done", fd_cnt, 1);
      chk("midflush_busy", busy_cnt, 10);
      // reset during a stalled writeback of set 1
      mem_v[1] = 4'b0100;
      mem_d[1] = 4'b0100;
      flush_start = 1'b1;
      plan_flush(20);
      tick();
      flush_start = 1'b0;
      for (int n = 0; n < 30 && !wb_valid; n++) tick();
      chk("rst_wb_reached", int'(wb_valid), 1);
      chk("rst_wb_set", int'(wb_set), 1);
      rst = 1'b0;
      #1;
      chk("rst_wbv_drop", int'(wb_valid), 0);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_clr", int'(mem_wr_rst_flush), 4'hf);
      chk("rst_set", int'(mem_set), 0);
      q.delete();
      stall_left = 0;
      dflt = rst_e();
      repeat (2) tick();
      release_init(-1);
      chk("reinit_cleared", int'(mem_v[1]), 0);
      start_flush(0, 0);
      chk("post_rst_done", fd_cnt, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
